// File: rtl/symbol_sync_framer.sv
// Hunts a 2-bit symbol stream for a 16-symbol sync word, then forwards one fixed-length payload.
// Optional build macro SYNC_ERR_TOL_EN: accept the sync word with at most one wrong symbol.
module symbol_sync_framer #(
  parameter logic [31:0] SYNC_WORD    = 32'hD391_7A5C,
  parameter int unsigned PAYLOAD_SYMS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_enable,
  input  logic [1:0]  demod_symbol,
  input  logic        demod_valid,
  output logic [1:0]  symbol_out,
  output logic        symbol_out_valid,
  output logic        frame_active,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [15:0] frame_count
);

  localparam logic [7:0] LastCount = 8'(PAYLOAD_SYMS - 1);
  localparam logic [4:0] FillMax   = 5'd16;

  typedef enum logic [0:0] {StHunt, StPayload} state_e;

  state_e      state_q, state_d;
  logic [31:0] hist_q, hist_d;
  logic [4:0]  fill_q, fill_d;
  logic [7:0]  count_q, count_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [1:0]  sym_out_q, sym_out_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;

  logic        accept;
  logic [31:0] next_hist;
  logic        word_match;
  logic        sync_hit;
  logic        last_sym;

  assign accept    = demod_valid & rx_enable;
  assign next_hist = {hist_q[29:0], demod_symbol};
  assign last_sym  = (count_q == LastCount);

`ifdef SYNC_ERR_TOL_EN
  logic [31:0] bit_diff;
  logic [15:0] pos_diff;

  always_comb begin
    bit_diff = next_hist ^ SYNC_WORD;
    for (int i = 0; i < 16; i++) begin
      pos_diff[i] = bit_diff[2*i] | bit_diff[2*i+1];
    end
  end

  // At most one position differs when clearing the lowest set bit leaves nothing.
  assign word_match = ((pos_diff & (pos_diff - 16'd1)) == 16'd0);
`else
  assign word_match = (next_hist == SYNC_WORD);
`endif

  assign sync_hit = (fill_q >= 5'd15) && word_match;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!rx_enable) begin
      state_d = StHunt;
    end else if (accept) begin
      unique case (state_q)
        StHunt:    if (sync_hit) state_d = StPayload;
        StPayload: if (last_sym) state_d = StHunt;
        default:   state_d = StHunt;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    hist_d        = hist_q;
    fill_d        = fill_q;
    count_d       = count_q;
    frame_count_d = frame_count_q;
    sym_out_d     = sym_out_q;
    valid_d       = 1'b0;
    done_d        = 1'b0;
    abort_d       = 1'b0;
    if (!rx_enable) begin
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
      abort_d = (state_q == StPayload) && (count_q != 8'd0);
    end else if (accept) begin
      unique case (state_q)
        StHunt: begin
          hist_d = next_hist;
          if (fill_q != FillMax) fill_d = fill_q + 5'd1;
          if (sync_hit) begin
            count_d       = '0;
            frame_count_d = frame_count_q + 16'd1;
          end
        end
        StPayload: begin
          sym_out_d = demod_symbol;
          valid_d   = 1'b1;
          count_d   = count_q + 8'd1;
          if (last_sym) begin
            done_d  = 1'b1;
            hist_d  = '0;
            fill_d  = '0;
            count_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q        <= '0;
      fill_q        <= '0;
      count_q       <= '0;
      frame_count_q <= '0;
      sym_out_q     <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      count_q       <= count_d;
      frame_count_q <= frame_count_d;
      sym_out_q     <= sym_out_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      abort_q       <= abort_d;
    end
  end

  // Outputs
  always_comb begin
    frame_active     = (state_q == StPayload);
    symbol_out       = sym_out_q;
    symbol_out_valid = valid_q;
    frame_done       = done_q;
    frame_abort      = abort_q;
    frame_count      = frame_count_q;
  end

endmodule

// File: tb/tb_symbol_sync_framer.sv
// Directed self-checking bench for symbol_sync_framer; a negedge monitor records the outputs.
module tb_symbol_sync_framer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_enable;
  logic [1:0]  demod_symbol;
  logic        demod_valid;
  logic [1:0]  symbol_out;
  logic        symbol_out_valid;
  logic        frame_active;
  logic        frame_done;
  logic        frame_abort;
  logic [15:0] frame_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0]  out_q[$];
  int          done_cnt;
  int          done_idx;
  int          abort_cnt;
  int          act_cnt;
  logic [15:0] exp_fc;
  logic [31:0] sw = 32'hD391_7A5C;

  symbol_sync_framer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rx_enable        (rx_enable),
    .demod_symbol     (demod_symbol),
    .demod_valid      (demod_valid),
    .symbol_out       (symbol_out),
    .symbol_out_valid (symbol_out_valid),
    .frame_active     (frame_active),
    .frame_done       (frame_done),
    .frame_abort      (frame_abort),
    .frame_count      (frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (symbol_out_valid) out_q.push_back(symbol_out);
    if (frame_done) begin
      done_cnt++;
      done_idx = out_q.size();
    end
    if (frame_abort) abort_cnt++;
    if (frame_active) act_cnt++;
  end

  task automatic clear_mon();
    out_q.delete();
    done_cnt  = 0;
    done_idx  = -1;
    abort_cnt = 0;
    act_cnt   = 0;
  endtask

  // Present one symbol for one clock; returns 1 time unit after the edge.
  task automatic drive(input logic [1:0] s, input logic v);
    demod_symbol = s;
    demod_valid  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 1'b0);
  endtask

  task automatic send_sync(input int flip_a, input int flip_b);
    logic [1:0] s;
    for (int i = 0; i < 16; i++) begin
      s = sw[31-2*i -: 2];
      if (i == flip_a || i == flip_b) s = s ^ 2'b11;
      drive(s, 1'b1);
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    rx_enable    = 1'b1;
    demod_symbol = 2'b00;
    demod_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({symbol_out, symbol_out_valid, frame_active, frame_done, frame_abort} !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b required 000000",
               {symbol_out, symbol_out_valid, frame_active, frame_done, frame_abort});
    end
    tests_run++;
    if (frame_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_frame_count: got %0d required 0", frame_count);
    end
    reset_n = 1'b1;
    exp_fc  = 16'd0;
    idle(2);
  endtask

  task automatic test_basic_frame();
    int bad = 0;
    clear_mon();
    send_sync(-1, -1);
    for (int i = 0; i < 64; i++) drive(2'(i % 4), 1'b1);
    idle(3);
    exp_fc = exp_fc + 16'd1;
    for (int i = 0; i < out_q.size() && i < 64; i++) if (out_q[i] !== 2'(i % 4)) bad++;
    tests_run++;
    if (out_q.size() != 64) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d symbols required 64", out_q.size());
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL basic_data: %0d wrong symbols, required 0", bad);
    end
    tests_run++;
    if (done_cnt != 1 || done_idx != 64) begin
      tests_failed++;
      $display("FAIL basic_done: got %0d pulses at symbol %0d required 1 at 64", done_cnt, done_idx);
    end
    tests_run++;
    if (frame_count !== exp_fc) begin
      tests_failed++;
      $display("FAIL basic_frame_count: got %0d required %0d", frame_count, exp_fc);
    end
    tests_run++;
    if (act_cnt != 64) begin
      tests_failed++;
      $display("FAIL basic_active: got %0d cycles required 64", act_cnt);
    end
    tests_run++;
    if (frame_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_back_to_hunt: frame_active got %b required 0", frame_active);
    end
  endtask

  task automatic test_toggle_valid();
    logic [39:0]  rnd = 40'h8F_6_1B_2_D_A_4_D;
    logic [127:0] blk_c = 128'h0123456789ABCDEF0123456789ABCDEF;
    logic [127:0] blk = '0;
    clear_mon();
    for (int i = 0; i < 20; i++) drive(rnd[39-2*i -: 2], 1'b1);
    send_sync(-1, -1);
    for (int i = 0; i < 64; i++) begin
      drive(blk_c[127-2*i -: 2], 1'b1);
      drive(2'b11, 1'b0);
    end
    idle(3);
    exp_fc = exp_fc + 16'd1;
    foreach (out_q[i]) blk = {blk[125:0], out_q[i]};
    tests_run++;
    if (out_q.size() != 64) begin
      tests_failed++;
      $display("FAIL toggle_count: got %0d symbols required 64", out_q.size());
    end
    tests_run++;
    if (blk !== blk_c) begin
      tests_failed++;
      $display("FAIL toggle_block: got %h required %h", blk, blk_c);
    end
  endtask

  task automatic test_sync_err();
    int exp_n;
    clear_mon();
    send_sync(7, -1);
    for (int i = 0; i < 64; i++) drive(2'b00, 1'b1);
    idle(3);
`ifdef SYNC_ERR_TOL_EN
    exp_n  = 64;
    exp_fc = exp_fc + 16'd1;
`else
    exp_n  = 0;
`endif
    tests_run++;
    if (out_q.size() != exp_n) begin
      tests_failed++;
      $display("FAIL one_flip_count: got %0d symbols required %0d", out_q.size(), exp_n);
    end
    tests_run++;
    if (frame_count !== exp_fc) begin
      tests_failed++;
      $display("FAIL one_flip_frame_count: got %0d required %0d", frame_count, exp_fc);
    end
    clear_mon();
    send_sync(7, 8);
    for (int i = 0; i < 64; i++) drive(2'b00, 1'b1);
    idle(3);
    tests_run++;
    if (out_q.size() != 0) begin
      tests_failed++;
      $display("FAIL two_flip_count: got %0d symbols required 0", out_q.size());
    end
    tests_run++;
    if (frame_count !== exp_fc) begin
      tests_failed++;
      $display("FAIL two_flip_frame_count: got %0d required %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_abort();
    clear_mon();
    send_sync(-1, -1);
    exp_fc = exp_fc + 16'd1;
    for (int i = 0; i < 30; i++) drive(2'(i % 4), 1'b1);
    rx_enable = 1'b0;
    for (int i = 0; i < 4; i++) drive(2'b01, 1'b1);
    tests_run++;
    if (abort_cnt != 1) begin
      tests_failed++;
      $display("FAIL abort_pulse: got %0d pulses required 1", abort_cnt);
    end
    tests_run++;
    if (frame_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_hunt: frame_active got %b required 0", frame_active);
    end
    tests_run++;
    if (act_cnt != 31) begin
      tests_failed++;
      $display("FAIL abort_active: got %0d cycles required 31", act_cnt);
    end
    tests_run++;
    if (frame_count !== exp_fc) begin
      tests_failed++;
      $display("FAIL abort_frame_count: got %0d required %0d", frame_count, exp_fc);
    end
    rx_enable = 1'b1;
    for (int i = 0; i < 20; i++) drive(2'(i % 4), 1'b1);
    idle(2);
    tests_run++;
    if (out_q.size() != 30) begin
      tests_failed++;
      $display("FAIL abort_no_more_out: got %0d symbols required 30", out_q.size());
    end
    tests_run++;
    if (abort_cnt != 1) begin
      tests_failed++;
      $display("FAIL abort_single: got %0d pulses required 1", abort_cnt);
    end
  endtask

  task automatic test_reset_mid_payload();
    clear_mon();
    send_sync(-1, -1);
    for (int i = 0; i < 20; i++) drive(2'(i % 4), 1'b1);
    reset_n = 1'b0;
    #2;
    tests_run++;
    if ({symbol_out, symbol_out_valid, frame_active, frame_done, frame_abort, frame_count}
        !== 22'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %h required 0",
               {symbol_out, symbol_out_valid, frame_active, frame_done, frame_abort, frame_count});
    end
    idle(2);
    reset_n = 1'b1;
    exp_fc  = 16'd0;
    idle(1);
    clear_mon();
    send_sync(-1, -1);
    for (int i = 0; i < 64; i++) drive(2'((i + 1) % 4), 1'b1);
    idle(3);
    exp_fc = exp_fc + 16'd1;
    tests_run++;
    if (out_q.size() != 64) begin
      tests_failed++;
      $display("FAIL midreset_count: got %0d symbols required 64", out_q.size());
    end
    tests_run++;
    if (done_cnt != 1) begin
      tests_failed++;
      $display("FAIL midreset_done: got %0d pulses required 1", done_cnt);
    end
    tests_run++;
    if (frame_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL midreset_frame_count: got %0d required 1", frame_count);
    end
  endtask

  task automatic test_sync_in_payload();
    logic [1:0] exp_sym[64];
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      exp_sym[i] = (i >= 10 && i <= 25) ? sw[31-2*(i-10) -: 2] : 2'(i % 4);
    end
    clear_mon();
    send_sync(-1, -1);
    for (int i = 0; i < 64; i++) drive(exp_sym[i], 1'b1);
    idle(3);
    exp_fc = exp_fc + 16'd1;
    for (int i = 0; i < out_q.size() && i < 64; i++) if (out_q[i] !== exp_sym[i]) bad++;
    tests_run++;
    if (out_q.size() != 64) begin
      tests_failed++;
      $display("FAIL embedded_count: got %0d symbols required 64", out_q.size());
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL embedded_data: %0d wrong symbols, required 0", bad);
    end
    tests_run++;
    if (frame_count !== exp_fc) begin
      tests_failed++;
      $display("FAIL embedded_frame_count: got %0d required %0d", frame_count, exp_fc);
    end
    tests_run++;
    if (done_cnt != 1) begin
      tests_failed++;
      $display("FAIL embedded_done: got %0d pulses required 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    for (int f = 0; f < 2; f++) begin
      send_sync(-1, -1);
      for (int i = 0; i < 64; i++) drive(2'((i + f) % 4), 1'b1);
    end
    idle(3);
    exp_fc = exp_fc + 16'd2;
    tests_run++;
    if (out_q.size() != 128) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d symbols required 128", out_q.size());
    end
    tests_run++;
    if (done_cnt != 2 || done_idx != 128) begin
      tests_failed++;
      $display("FAIL b2b_done: got %0d pulses last at %0d required 2 at 128", done_cnt, done_idx);
    end
    tests_run++;
    if (frame_count !== exp_fc) begin
      tests_failed++;
      $display("FAIL b2b_frame_count: got %0d required %0d", frame_count, exp_fc);
    end
    tests_run++;
    if (act_cnt != 128) begin
      tests_failed++;
      $display("FAIL b2b_active: got %0d cycles required 128", act_cnt);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic_frame();
    test_toggle_valid();
    test_sync_err();
    test_abort();
    test_reset_mid_payload();
    test_sync_in_payload();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
